vend_credit_fsm: RTL and testbench

//  Downstream consumer of the per-button debouncers in the vending machine.
//  - Turns debounced coin/select levels into single-cycle events.
//  - Accumulates credit and vends when credit >= PRICE.
//  - Drives the dispense strobe and reports change owed.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_edge_det.sv | 19 +
 rtl/vend_credit_fsm.sv | 134 +++++++++++++
 tb/tb_vend_credit_fsm.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine credit logic.
// Holds the FSM state encoding, the coin values and the dispense-counter sizing helper.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DISPENSE,
    CHANGE
  } vend_state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;
  localparam int COIN25_VAL = 25;

  function automatic int disp_cnt_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Rising-edge detector for one debounced level: o_evt is combinational, the history reg is registered.
// History resets to 1 so a level already high when reset releases produces no event.
module vend_edge_det (
  input  logic clk,
  input  logic n_reset,
  input  logic i_lvl,
  output logic o_evt
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (n_reset) r_prev <= 1'b1;
    else         r_prev <= i_lvl;
  end

  assign o_evt = i_lvl & ~r_prev;

endmodule

// File: rtl/vend_credit_fsm.sv
// Credit/vend FSM: coin and select edges -> registered credit, reject, dispense, change (1-cycle latency).
// Optional cancel path compiled in with VEND_CANCEL_EN; no backpressure, events outside IDLE/ACCUM are refused or ignored.
module vend_credit_fsm
  import vend_pkg::*;
#(
  parameter int CW           = 8,
  parameter int PRICE        = 65,
  parameter int MAX_CREDIT   = 100,
  parameter int DISPENSE_CYC = 4
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          coin5_db,
  input  logic          coin10_db,
  input  logic          coin25_db,
  input  logic          sel_db,
`ifdef VEND_CANCEL_EN
  input  logic          cancel_db,
`endif
  output logic [CW-1:0] credit,
  output logic          coin_reject,
  output logic          dispense,
  output logic          change_vld,
  output logic [CW-1:0] change_amt
);

  localparam int CNT_W = disp_cnt_w(DISPENSE_CYC);
  localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(DISPENSE_CYC - 1);
  localparam logic [CW-1:0]    LP_PRICE    = CW'(PRICE);
  localparam logic [CW:0]      LP_MAX      = (CW+1)'(MAX_CREDIT);
  localparam logic [CW:0]      LP_V5       = (CW+1)'(COIN5_VAL);
  localparam logic [CW:0]      LP_V10      = (CW+1)'(COIN10_VAL);
  localparam logic [CW:0]      LP_V25      = (CW+1)'(COIN25_VAL);

  logic w_evt5, w_evt10, w_evt25, w_sel, w_cancel;

  vend_edge_det u_edge_c5  (.clk(clk), .n_reset(n_reset), .i_lvl(coin5_db),  .o_evt(w_evt5));
  vend_edge_det u_edge_c10 (.clk(clk), .n_reset(n_reset), .i_lvl(coin10_db), .o_evt(w_evt10));
  vend_edge_det u_edge_c25 (.clk(clk), .n_reset(n_reset), .i_lvl(coin25_db), .o_evt(w_evt25));
  vend_edge_det u_edge_sel (.clk(clk), .n_reset(n_reset), .i_lvl(sel_db),    .o_evt(w_sel));
`ifdef VEND_CANCEL_EN
  vend_edge_det u_edge_can (.clk(clk), .n_reset(n_reset), .i_lvl(cancel_db), .o_evt(w_cancel));
`else
  assign w_cancel = 1'b0;
`endif

  vend_state_t      r_state;
  logic [CW-1:0]    r_credit;
  logic             r_coin_reject;
  logic             r_dispense;
  logic             r_change_vld;
  logic [CW-1:0]    r_change_amt;
  logic [CNT_W-1:0] r_cnt;

  logic          w_coin_any;
  logic          w_coin_multi;
  logic [CW:0]   w_coin_val;
  logic [CW:0]   w_sum;

  // Highest-value coin wins; any other simultaneous coins fold into the single reject pulse.
  always_comb begin
    w_coin_val = '0;
    if (w_evt25)      w_coin_val = LP_V25;
    else if (w_evt10) w_coin_val = LP_V10;
    else if (w_evt5)  w_coin_val = LP_V5;
  end

  assign w_coin_any   = w_evt5 | w_evt10 | w_evt25;
  assign w_coin_multi = (w_evt25 & (w_evt10 | w_evt5)) | (w_evt10 & w_evt5);
  assign w_sum        = {1'b0, r_credit} + w_coin_val;

  always_ff @(posedge clk) begin
    if (n_reset) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_coin_reject <= 1'b0;
      r_dispense    <= 1'b0;
      r_change_vld  <= 1'b0;
      r_change_amt  <= '0;
      r_cnt         <= '0;
    end else begin
      r_coin_reject <= 1'b0;
      r_change_vld  <= 1'b0;
      r_change_amt  <= '0;
      case (r_state)
        IDLE, ACCUM: begin
          if (w_cancel && r_state == ACCUM) begin
            r_state       <= CHANGE;
            r_change_vld  <= 1'b1;
            r_change_amt  <= r_credit;
            r_coin_reject <= w_coin_any;
          end else if (w_sel && r_state == ACCUM && r_credit >= LP_PRICE) begin
            r_state       <= DISPENSE;
            r_dispense    <= 1'b1;
            r_cnt         <= LP_CNT_INIT;
            r_coin_reject <= w_coin_any;
          end else if (w_coin_any) begin
            if (w_sum <= LP_MAX) begin
              r_credit      <= w_sum[CW-1:0];
              r_state       <= ACCUM;
              r_coin_reject <= w_coin_multi;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end
        DISPENSE: begin
          r_coin_reject <= w_coin_any;
          if (r_cnt == '0) begin
            r_dispense   <= 1'b0;
            r_state      <= CHANGE;
            r_change_vld <= 1'b1;
            r_change_amt <= r_credit - LP_PRICE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        CHANGE: begin
          r_coin_reject <= w_coin_any;
          r_credit      <= '0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign credit      = r_credit;
  assign coin_reject = r_coin_reject;
  assign dispense    = r_dispense;
  assign change_vld  = r_change_vld;
  assign change_amt  = r_change_amt;

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: timeline-based reference model checked every cycle, directed scenarios, random stimulus.
module tb_vend_credit_fsm;

  localparam int CW    = 8;
  localparam int PRICE = 65;
  localparam int MAXC  = 100;
  localparam int DC    = 4;

  logic          clk = 1'b0;
  logic          n_reset = 1'b1;
  logic [3:0]    lv = 4'b0;   // {sel, coin25, coin10, coin5}
  logic [CW-1:0] credit;
  logic          coin_reject, dispense, change_vld;
  logic [CW-1:0] change_amt;
`ifdef VEND_CANCEL_EN
  logic          cancel_lv = 1'b0;
`endif

  always #5 clk = ~clk;

  vend_credit_fsm #(.CW(CW), .PRICE(PRICE), .MAX_CREDIT(MAXC), .DISPENSE_CYC(DC)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .coin5_db   (lv[0]),
    .coin10_db  (lv[1]),
    .coin25_db  (lv[2]),
    .sel_db     (lv[3]),
`ifdef VEND_CANCEL_EN
    .cancel_db  (cancel_lv),
`endif
    .credit     (credit),
    .coin_reject(coin_reject),
    .dispense   (dispense),
    .change_vld (change_vld),
    .change_amt (change_amt)
  );

  int n_chk = 0, n_pass = 0;
  int n_disp = 0, n_chg = 0, n_rej = 0, last_amt = -1;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: each edge index k schedules the vend/cancel timeline from absolute edge numbers.
  int k = 0, m_credit = 0, busy_end = -1, disp_end = -1, chg_edge = -1, chg_val = 0, clr_edge = -1;
  bit p5 = 1, p10 = 1, p25 = 1, psel = 1, pcan = 1;
  bit e_rej = 0, e_disp = 0, e_cv = 0;
  int e_amt = 0;

  always @(posedge clk) begin
    bit ev5, ev10, ev25, evsel, evcan;
    int nco, val;
    k++;
    if (n_reset) begin
      m_credit = 0; busy_end = -1; disp_end = -1; chg_edge = -1; clr_edge = -1; chg_val = 0;
      p5 = 1; p10 = 1; p25 = 1; psel = 1; pcan = 1;
      e_rej = 0; e_disp = 0; e_cv = 0; e_amt = 0;
    end else begin
      ev5 = lv[0] & ~p5; ev10 = lv[1] & ~p10; ev25 = lv[2] & ~p25; evsel = lv[3] & ~psel;
      p5 = lv[0]; p10 = lv[1]; p25 = lv[2]; psel = lv[3];
`ifdef VEND_CANCEL_EN
      evcan = cancel_lv & ~pcan; pcan = cancel_lv;
`else
      evcan = 1'b0;
`endif
      nco = int'(ev5) + int'(ev10) + int'(ev25);
      val = ev25 ? 25 : (ev10 ? 10 : (ev5 ? 5 : 0));
      e_rej = 0;
      if (k <= busy_end) begin
        e_rej = (nco != 0);
      end else if (evcan && m_credit > 0) begin
        chg_edge = k; chg_val = m_credit; clr_edge = k + 1; busy_end = k + 1;
        e_rej = (nco != 0);
      end else if (evsel && m_credit >= PRICE) begin
        disp_end = k + DC - 1; chg_edge = k + DC; chg_val = m_credit - PRICE;
        clr_edge = k + DC + 1; busy_end = k + DC + 1;
        e_rej = (nco != 0);
      end else if (nco != 0) begin
        if (m_credit + val <= MAXC) begin
          m_credit += val;
          e_rej = (nco > 1);
        end else begin
          e_rej = 1;
        end
      end
      if (k == clr_edge) m_credit = 0;
      e_disp = (k <= disp_end);
      e_cv   = (k == chg_edge);
      e_amt  = e_cv ? chg_val : 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("credit", credit, m_credit);
      check("coin_reject", coin_reject, e_rej);
      check("dispense", dispense, e_disp);
      check("change_vld", change_vld, e_cv);
      check("change_amt", change_amt, e_amt);
      if (dispense) n_disp++;
      if (coin_reject) n_rej++;
      if (change_vld) begin n_chg++; last_amt = change_amt; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input logic [3:0] m);
    lv = m; tick(); lv = 4'b0; tick();
  endtask

  task automatic do_reset();
    n_reset = 1'b1; tick(); tick(); n_reset = 1'b0; tick();
  endtask

  int d0, c0, r0;

  initial begin
    tick(); tick();
    chk_en = 1'b1;
    check("rst_credit", credit, 0);
    check("rst_reject", coin_reject, 0);
    check("rst_dispense", dispense, 0);
    check("rst_change_vld", change_vld, 0);
    check("rst_change_amt", change_amt, 0);
    n_reset = 1'b0; tick();

    // 25,25,10,5 then select: exact price, zero change
    pulse(4'b0100); pulse(4'b0100); pulse(4'b0010); pulse(4'b0001);
    check("t1_credit", credit, 65);
    check("t1_model_credit", m_credit, 65);
    d0 = n_disp; c0 = n_chg;
    pulse(4'b1000); idle(8);
    check("t1_disp_cycles", n_disp - d0, 4);
    check("t1_chg_pulses", n_chg - c0, 1);
    check("t1_chg_amt", last_amt, 0);
    check("t1_credit_after", credit, 0);

    // 90 + quarter refused, then vend returns 25
    pulse(4'b0100); pulse(4'b0100); pulse(4'b0100); pulse(4'b0010); pulse(4'b0001);
    r0 = n_rej;
    pulse(4'b0100);
    check("t2_rej", n_rej - r0, 1);
    check("t2_credit", credit, 90);
    pulse(4'b1000); idle(8);
    check("t2_chg_amt", last_amt, 25);
    check("t2_model_amt", chg_val, 25);

    // exactly MAX_CREDIT is accepted
    r0 = n_rej;
    pulse(4'b0100); pulse(4'b0100); pulse(4'b0100); pulse(4'b0100);
    check("t2b_credit_max", credit, 100);
    check("t2b_rej", n_rej - r0, 0);
    pulse(4'b1000); idle(8);
    check("t2b_chg_amt", last_amt, 35);

    // dime + quarter together
    do_reset();
    r0 = n_rej;
    pulse(4'b0110);
    check("t3_credit", credit, 25);
    check("t3_rej", n_rej - r0, 1);

    // select below price ignored; coin during dispense refused
    pulse(4'b0100);
    d0 = n_disp;
    pulse(4'b1000); idle(3);
    check("t4_no_disp", n_disp - d0, 0);
    check("t4_credit50", credit, 50);
    pulse(4'b0100);
    d0 = n_disp; r0 = n_rej;
    lv = 4'b1000; tick(); lv = 4'b0010; tick(); lv = 4'b0000; tick();
    check("t4_credit_hold", credit, 75);
    idle(8);
    check("t4_rej", n_rej - r0, 1);
    check("t4_disp_cycles", n_disp - d0, 4);
    check("t4_chg_amt", last_amt, 10);

    // quarter level held through reset release
    r0 = n_rej;
    n_reset = 1'b1; lv = 4'b0100; tick(); tick();
    n_reset = 1'b0; idle(3);
    check("t5_credit", credit, 0);
    check("t5_rej", n_rej - r0, 0);
    lv = 4'b0; tick();

`ifdef VEND_CANCEL_EN
    // cancel beats select at credit 40
    pulse(4'b0100); pulse(4'b0010); pulse(4'b0001);
    d0 = n_disp;
    lv = 4'b1000; cancel_lv = 1'b1; tick(); lv = 4'b0; cancel_lv = 1'b0; idle(4);
    check("t6_chg_amt", last_amt, 40);
    check("t6_no_disp", n_disp - d0, 0);
    check("t6_credit", credit, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        n_reset = 1'b1; tick(); n_reset = 1'b0;
      end
      for (int b = 0; b < 4; b++) lv[b] = ($urandom_range(0, 2) == 0);
`ifdef VEND_CANCEL_EN
      cancel_lv = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    lv = 4'b0;
    idle(10);
    chk_en = 1'b0;
    check("rand_vended", (n_disp > 0) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
